// File: rtl/vga_sync_if.sv
// Scan-timing bundle from the VGA sync generator to the pixel generators.
// The master drives it and pixel logic samples it combinationally.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
    logic [9:0] x;
    logic [9:0] y;

    modport master (
        output hsync, vsync, video_on, p_tick, frame_tick, x, y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, frame_tick, x, y
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing source: divides the board clock into a pixel strobe,
// runs the scan counters, and produces registered active-low sync pulses.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    vga_sync_if.master  vga
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       h_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_cnt;
    logic [9:0]       v_next;
    logic             hsync_q;
    logic             vsync_q;
    logic             p_tick;

    assign p_tick = (div_cnt == DIV_MAX);

    // Out-of-range counts (e.g. after an upset) fall back to 0 on the next pixel tick.
    always_comb begin
        div_next = (div_cnt >= DIV_MAX) ? '0 : div_cnt + 1'b1;
        h_next   = h_cnt;
        v_next   = v_cnt;
        if (p_tick) begin
            h_next = (h_cnt >= H_MAX) ? '0 : h_cnt + 10'd1;
            if (v_cnt > V_MAX) begin
                v_next = '0;
            end else if (h_cnt == H_MAX) begin
                v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counts so they switch on the same edge as x/y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_cnt <= div_next;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync_q <= !((h_next >= HS_START) && (h_next <= HS_END));
            vsync_q <= !((v_next >= VS_START) && (v_next <= VS_END));
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.p_tick     = p_tick;
    assign vga.x          = h_cnt;
    assign vga.y          = v_cnt;
    assign vga.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign vga.frame_tick = p_tick && (h_cnt == H_MAX) && (v_cnt == V_MAX);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line/reset timing, a shrunken
// instance (15x9 totals) so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   num_checks = 0;
    int   num_errors = 0;

    vga_sync_if vga_d ();
    vga_sync_if vga_s ();

    vga_sync_gen dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_d)
    );

    vga_sync_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .CLK_DIV   (4)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_s)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        num_checks++;
        if (observed != expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string pfx);
        reset = 1'b0;
        repeat (10) tick();
        check_output({pfx, "_x"}, vga_d.x, 0);
        check_output({pfx, "_y"}, vga_d.y, 0);
        check_output({pfx, "_hsync"}, vga_d.hsync, 1);
        check_output({pfx, "_vsync"}, vga_d.vsync, 1);
        check_output({pfx, "_video_on"}, vga_d.video_on, 1);
        check_output({pfx, "_p_tick"}, vga_d.p_tick, 0);
        check_output({pfx, "_frame_tick"}, vga_d.frame_tick, 0);
        reset = 1'b1;
    endtask

    // Two full lines from (0,0); c counts clk edges since reset release.
    task automatic line_test(input string pfx);
        int   x_err, hs_low, von_cnt, ft_cnt;
        int   hs_fall1, hs_fall2, hs_fall_x, hs_rise_x, von_fall_x, y_step;
        logic hs_prev, von_prev;
        int   y_prev;
        x_err = 0; hs_low = 0; von_cnt = 0; ft_cnt = 0;
        hs_fall1 = -1; hs_fall2 = -1; hs_fall_x = -1; hs_rise_x = -1;
        von_fall_x = -1; y_step = -1;
        hs_prev = vga_d.hsync; von_prev = vga_d.video_on; y_prev = int'(vga_d.y);
        for (int c = 0; c < 6400; c++) begin
            if (c > 0) tick();
            if (int'(vga_d.x) != (c / 4) % 800) x_err++;
            if (c < 3200 && !vga_d.hsync) hs_low++;
            if (c < 3200 && vga_d.video_on) von_cnt++;
            if (vga_d.frame_tick) ft_cnt++;
            if (hs_prev && !vga_d.hsync) begin
                if (hs_fall1 < 0) begin
                    hs_fall1  = c;
                    hs_fall_x = int'(vga_d.x);
                end else if (hs_fall2 < 0) begin
                    hs_fall2 = c;
                end
            end
            if (!hs_prev && vga_d.hsync && hs_rise_x < 0) hs_rise_x = int'(vga_d.x);
            if (von_prev && !vga_d.video_on && von_fall_x < 0) von_fall_x = int'(vga_d.x);
            if (int'(vga_d.y) != y_prev && y_step < 0) y_step = c;
            hs_prev  = vga_d.hsync;
            von_prev = vga_d.video_on;
            y_prev   = int'(vga_d.y);
        end
        check_output({pfx, "_x_sequence_errs"}, x_err, 0);
        check_output({pfx, "_hsync_low_clks"}, hs_low, 384);
        check_output({pfx, "_hsync_fall_x"}, hs_fall_x, 656);
        check_output({pfx, "_hsync_rise_x"}, hs_rise_x, 752);
        check_output({pfx, "_hsync_period"}, hs_fall2 - hs_fall1, 3200);
        check_output({pfx, "_video_fall_x"}, von_fall_x, 640);
        check_output({pfx, "_video_on_clks"}, von_cnt, 2560);
        check_output({pfx, "_y_step_clk"}, y_step, 3200);
        check_output({pfx, "_y_end"}, vga_d.y, 1);
        check_output({pfx, "_frame_ticks"}, ft_cnt, 0);
    endtask

    // Three back-to-back frames on the small instance (540 clks per frame).
    task automatic frame_test();
        int   ft_at[3];
        int   ft_cnt, vs_low, vs_fall_y, von_cnt, hs_falls, hs_gap_err, last_fall;
        int   x_wrap, y_wrap, y_last;
        logic hs_prev, vs_prev;
        ft_cnt = 0; vs_low = 0; vs_fall_y = -1; von_cnt = 0;
        hs_falls = 0; hs_gap_err = 0; last_fall = -1;
        x_wrap = -1; y_wrap = -1; y_last = -1;
        ft_at[0] = -1; ft_at[1] = -1; ft_at[2] = -1;
        hs_prev = vga_s.hsync; vs_prev = vga_s.vsync;
        for (int c = 0; c < 1700; c++) begin
            if (c > 0) tick();
            if (vga_s.frame_tick) begin
                if (ft_cnt < 3) ft_at[ft_cnt] = c;
                ft_cnt++;
            end
            if (c < 540 && !vga_s.vsync) vs_low++;
            if (c < 540 && vga_s.video_on) von_cnt++;
            if (vs_prev && !vga_s.vsync && vs_fall_y < 0) vs_fall_y = int'(vga_s.y);
            if (hs_prev && !vga_s.hsync) begin
                if (last_fall >= 0 && c - last_fall != 60) hs_gap_err++;
                last_fall = c;
                hs_falls++;
            end
            if (c == 539) y_last = int'(vga_s.y);
            if (c == 540) begin
                x_wrap = int'(vga_s.x);
                y_wrap = int'(vga_s.y);
            end
            hs_prev = vga_s.hsync;
            vs_prev = vga_s.vsync;
        end
        check_output("frame_tick_count", ft_cnt, 3);
        check_output("frame_tick_first_clk", ft_at[0], 539);
        check_output("frame_tick_spacing_1", ft_at[1] - ft_at[0], 540);
        check_output("frame_tick_spacing_2", ft_at[2] - ft_at[1], 540);
        check_output("vsync_low_clks", vs_low, 120);
        check_output("vsync_fall_y", vs_fall_y, 5);
        check_output("frame_video_on_clks", von_cnt, 128);
        check_output("frame_last_y", y_last, 8);
        check_output("frame_wrap_x", x_wrap, 0);
        check_output("frame_wrap_y", y_wrap, 0);
        check_output("hsync_falls", hs_falls, 28);
        check_output("hsync_gap_errs", hs_gap_err, 0);
    endtask

    initial begin
        int guard;
        $display("[TB] start");

        do_reset("rst0");
        tick();
        check_output("div_edge1_p_tick", vga_d.p_tick, 0);
        tick();
        check_output("div_edge2_p_tick", vga_d.p_tick, 0);
        tick();
        check_output("div_edge3_p_tick", vga_d.p_tick, 1);
        check_output("div_edge3_x", vga_d.x, 0);
        tick();
        check_output("div_edge4_x", vga_d.x, 1);
        check_output("div_edge4_p_tick", vga_d.p_tick, 0);

        do_reset("rst1");
        line_test("line");

        guard = 0;
        while (vga_d.x != 10'd300 && guard < 4000) begin
            tick();
            guard++;
        end
        check_output("reach_x300", vga_d.x, 300);
        check_output("reach_y", vga_d.y, 2);
        #2 reset = 1'b0;
        #1;
        check_output("async_rst_x", vga_d.x, 0);
        check_output("async_rst_y", vga_d.y, 0);
        check_output("async_rst_hsync", vga_d.hsync, 1);
        check_output("async_rst_vsync", vga_d.vsync, 1);
        check_output("async_rst_p_tick", vga_d.p_tick, 0);
        repeat (3) tick();
        reset = 1'b1;
        line_test("post_rst");

        do_reset("rst2");
        frame_test();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing source for the VGA path on the Basys 3.
- Divides the 100 MHz board clock into a 25 MHz pixel-enable strobe.
- Runs horizontal and vertical scan counters for 640x480 @ 60 Hz.
- Drives hsync/vsync to the connector, and drives x, y and video_on to the pixel generators (e.g. the bouncing-square logic), which consume them combinationally.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel (100 MHz / 25 MHz)

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
hsync  output  1  horizontal sync, active low, registered
vsync  output  1  vertical sync, active low, registered
video_on  output  1  high while (x, y) is inside the visible area
p_tick  output  1  one-clk pixel-enable pulse, once every CLK_DIV clks
frame_tick  output  1  one-clk pulse on the last pixel tick of a frame
x  output  10  current horizontal pixel count, 0..H_TOTAL-1
y  output  10  current vertical line count, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
  - HS_START = H_DISPLAY+H_FRONT = 656; HS_END = HS_START+H_SYNC-1 = 751.
  - VS_START = V_DISPLAY+V_FRONT = 490; VS_END = VS_START+V_SYNC-1 = 491.
- Reset (reset==0, asynchronous) sets: div_cnt=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1. Hence p_tick=0, frame_tick=0, x=0, y=0, video_on=1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt==CLK_DIV-1), combinational.
  - First p_tick is in the 4th clk after reset release.
- Horizontal counter:
  - On a clk edge with p_tick=1: h_cnt <= (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
  - Otherwise h_cnt holds.
  - Each x value is therefore stable for exactly CLK_DIV clks.
- Vertical counter:
  - Advances only on an edge where p_tick=1 and h_cnt==H_TOTAL-1.
  - On that edge: v_cnt <= (v_cnt==V_TOTAL-1) ? 0 : v_cnt+1.
- Sync outputs:
  - Registered from the next-state counter values, so hsync/vsync change on the same edge as x/y (zero lag relative to the counters).
  - hsync==0 iff HS_START <= x <= HS_END.
  - vsync==0 iff VS_START <= y <= VS_END.
- Other outputs:
  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY), combinational.
  - frame_tick = p_tick && x==H_TOTAL-1 && y==V_TOTAL-1.
  - x = h_cnt and y = v_cnt, direct.
- Wrap: (799,524) -> (0,0) occurs in a single pixel tick; frame_tick is high in the clk preceding that edge.
- Timing totals:
  - Line = 800 pixel ticks = 3200 clks.
  - Frame = 420000 pixel ticks = 1,680,000 clks (~59.52 Hz).
- Reset mid-frame: all state returns to reset values immediately, without waiting for a clk edge. After release, the scan restarts at (0,0) with the full 4-clk divider phase.
- Counters never exceed their TOTAL-1. If an out-of-range value is forced (e.g. by an SEU), the next p_tick wraps that counter to 0.

Test Plan:
- Reset: hold reset=0 for 10 clks, then release -> x=0, y=0, hsync=1, vsync=1, video_on=1; first p_tick in clk 4; x=1 after 4 clks.
- Line timing: run one full line -> x steps 0..799 with each value held 4 clks; hsync low for exactly 384 clks, starting when x becomes 656 and ending when x becomes 752; y increments once as x wraps 799->0.
- Frame timing: run 1,680,000 clks -> exactly 1 frame_tick at (799,524); vsync low for exactly 6400 clks spanning y=490..491; counters return to (0,0).
- Video window: count clks with video_on=1 over one frame -> 307200 pixel ticks (1,228,800 clks); video_on falls when x becomes 640 or y becomes 480.
- Mid-frame reset: assert reset=0 asynchronously (between edges) at (x=300, y=250) -> outputs return to reset values before the next clk edge; after release, hsync/line timing matches the line-timing test from (0,0).
- Back-to-back frames: run 3 frames -> frame_tick spacing is 1,680,000 clks each; hsync period is 3200 clks with no gaps across vertical wraps.
